// File: rtl/serial_rx_pkg.sv
// Shared definitions for the enable-gated serial link (receiver and future transmitter).
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } rx_state_t;

  // Level the line rests at between frames; a start bit is the opposite level.
  localparam logic IDLE_LEVEL = 1'b1;

  // Bit-counter width for a frame of `width` data bits, never narrower than 1.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_rx_if.sv
// Serial line in, parallel word out (valid/ready) plus receiver status.
interface serial_rx_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             d;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             busy;
  logic             frame_err;
  logic             overrun;

  // Transmitter/consumer side.
  modport master (
    output en, d, ready,
    input  data, valid, busy, frame_err, overrun
  );

  // Receiver side.
  modport slave (
    input  en, d, ready,
    output data, valid, busy, frame_err, overrun
  );
endinterface

// File: rtl/serial_rx_sipo.sv
// Right-shifting serial-in/parallel-out register; the first bit shifted in ends at bit 0.
module sipo_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  generate
    if (WIDTH == 1) begin : g_one
      // Single-bit word: just capture the line.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)      r_q <= '0;
        else if (i_en) r_q <= i_d;
      end
    end else begin : g_multi
      // New bit enters at the MSB, older bits move toward the LSB.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)      r_q <= '0;
        else if (i_en) r_q <= {i_d, r_q[WIDTH-1:1]};
      end
    end
  endgenerate

  assign o_q = r_q;
endmodule

// File: rtl/serial_rx.sv
// Frame receiver: start bit, WIDTH data bits LSB-first, stop bit, advanced only on `en`.
module serial_rx
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  serial_rx_if.slave  bus
);
  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  rx_state_t        r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] w_shift_q;
  logic [WIDTH-1:0] r_data;
  logic             r_valid, r_busy, r_ferr, r_ovr;
  logic             w_shift_en, w_stop_stb, w_load, w_drop, w_ferr, w_consume;

  assign w_shift_en = bus.en && (r_state == DATA);

  sipo_shift #(.WIDTH(WIDTH)) u_sipo (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_shift_en),
    .i_d  (bus.d),
    .o_q  (w_shift_q)
  );

  // State and bit-count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: everything holds unless the strobe is present.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (bus.en) begin
      unique case (r_state)
        IDLE: if (bus.d != IDLE_LEVEL) begin
          w_state_nxt = DATA;
          w_cnt_nxt   = '0;
        end
        DATA: begin
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_cnt == LAST) w_state_nxt = STOP;
        end
        STOP:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Stop-bit decisions: deliver, drop as overrun, or flag a framing error.
  always_comb begin
    w_stop_stb = bus.en && (r_state == STOP);
    w_load     = w_stop_stb &&  bus.d && (!r_valid || bus.ready);
    w_drop     = w_stop_stb &&  bus.d &&   r_valid && !bus.ready;
    w_ferr     = w_stop_stb && !bus.d;
    w_consume  = r_valid && bus.ready;
  end

  // Registered outputs; a load wins over a consume on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_load) begin
        r_data  <= w_shift_q;
        r_valid <= 1'b1;
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end
      r_busy <= (w_state_nxt != IDLE);
      r_ferr <= w_ferr;
      r_ovr  <= r_ovr | w_drop;
    end
  end

  assign bus.data      = r_data;
  assign bus.valid     = r_valid;
  assign bus.busy      = r_busy;
  assign bus.frame_err = r_ferr;
  assign bus.overrun   = r_ovr;
endmodule

// File: tb/tb_serial_rx.sv
// Bench for serial_rx: directed frame table, corner sequences, randomized frames vs. a frame-level model.
module tb_serial_rx;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_rx_if #(.WIDTH(W)) intf ();
  serial_rx #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(intf));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: what the consumer should see, tracked per frame and per handshake.
  logic [W-1:0] m_data;
  logic         m_valid, m_busy, m_ferr, m_ovr;
  logic [W-1:0] cur_word;

  typedef struct {
    bit           do_rst;
    logic [W-1:0] word;
    bit           stop;
    int           gap;
    bit           rbase;
    bit           rstop;
    logic         ev;
    logic [W-1:0] ed;
    logic         ef;
    logic         eo;
  } vec_t;
  vec_t tv[8];

  task automatic cmp(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    cmp({tag, ".data"},  intf.data, m_data);
    cmp({tag, ".valid"}, W'(intf.valid), W'(m_valid));
    cmp({tag, ".busy"},  W'(intf.busy), W'(m_busy));
    cmp({tag, ".ferr"},  W'(intf.frame_err), W'(m_ferr));
    cmp({tag, ".ovr"},   W'(intf.overrun), W'(m_ovr));
  endtask

  task automatic model_reset();
    m_data = '0; m_valid = 0; m_busy = 0; m_ferr = 0; m_ovr = 0;
  endtask

  // One clock: apply inputs, advance the model for that edge, then compare.
  task automatic tick(input bit e, input bit b, input bit r, input bit stop_stb, input bit nbusy);
    bit ld, ov;
    intf.en = e; intf.d = b; intf.ready = r;
    ld = stop_stb &&  b && (!m_valid || r);
    ov = stop_stb &&  b &&   m_valid && !r;
    @(posedge clk); #1;
    m_ferr = stop_stb && !b;
    if (ld) begin
      m_data  = cur_word;
      m_valid = 1;
    end else if (m_valid && r) m_valid = 0;
    m_ovr  = m_ovr | ov;
    m_busy = nbusy;
    check_all("cyc");
  endtask

  // Whole frame; `gap` idle cycles (en=0, line noise) before every strobe.
  task automatic send_frame(input logic [W-1:0] w, input bit stop, input int gap,
                            input bit rbase, input bit rstop, input bit rnd);
    bit bv, r;
    cur_word = w;
    for (int i = 0; i < W + 2; i++) begin
      for (int g = 0; g < gap; g++)
        tick(0, 1'($urandom_range(0, 1)), rnd ? 1'($urandom_range(0, 1)) : rbase, 0, m_busy);
      if (i == 0) bv = 0;
      else if (i == W + 1) bv = stop;
      else bv = w[i-1];
      if (rnd) r = 1'($urandom_range(0, 1));
      else     r = (i == W + 1) ? rstop : rbase;
      tick(1, bv, r, i == W + 1, i != W + 1);
    end
  endtask

  task automatic do_reset();
    #1 rst = 1'b0;
    #1;
    cmp("rst.data",  intf.data, '0);
    cmp("rst.valid", W'(intf.valid), '0);
    cmp("rst.busy",  W'(intf.busy), '0);
    cmp("rst.ferr",  W'(intf.frame_err), '0);
    cmp("rst.ovr",   W'(intf.overrun), '0);
    model_reset();
    @(posedge clk); #1 rst = 1'b1;
  endtask

  initial begin
    intf.en = 0; intf.d = 1; intf.ready = 0;
    model_reset();
    cur_word = '0;
    //            rst  word   stop gap rb rs  ev  ed     ef eo
    tv[0] = '{0, 8'hA5, 1, 0, 1, 1, 1, 8'hA5, 0, 0};
    tv[1] = '{0, 8'h3C, 1, 2, 1, 1, 1, 8'h3C, 0, 0};
    tv[2] = '{0, 8'hFF, 0, 0, 1, 1, 0, 8'h3C, 1, 0};
    tv[3] = '{0, 8'h01, 1, 0, 1, 1, 1, 8'h01, 0, 0};
    tv[4] = '{0, 8'h11, 1, 0, 0, 0, 1, 8'h11, 0, 0};
    tv[5] = '{0, 8'h22, 1, 0, 0, 0, 1, 8'h11, 0, 1};
    tv[6] = '{1, 8'h11, 1, 0, 0, 0, 1, 8'h11, 0, 0};
    tv[7] = '{0, 8'h22, 1, 0, 0, 1, 1, 8'h22, 0, 0};

    // Reset state while reset is held from time zero.
    #2;
    cmp("init.data",  intf.data, '0);
    cmp("init.valid", W'(intf.valid), '0);
    cmp("init.busy",  W'(intf.busy), '0);
    cmp("init.ferr",  W'(intf.frame_err), '0);
    cmp("init.ovr",   W'(intf.overrun), '0);
    @(posedge clk); #1 rst = 1'b1;

    for (int k = 0; k < 8; k++) begin
      if (tv[k].do_rst) do_reset();
      send_frame(tv[k].word, tv[k].stop, tv[k].gap, tv[k].rbase, tv[k].rstop, 0);
      cmp("vec.valid", W'(intf.valid), W'(tv[k].ev));
      cmp("vec.data",  intf.data, tv[k].ed);
      cmp("vec.ferr",  W'(intf.frame_err), W'(tv[k].ef));
      cmp("vec.ovr",   W'(intf.overrun), W'(tv[k].eo));
      tick(0, 1, tv[k].rbase, 0, 0);
      if (k == 5) begin
        // Overrun aftermath: consuming clears valid, overrun stays sticky.
        tick(0, 1, 1, 0, 0);
        cmp("ovr.valid_after_ready", W'(intf.valid), '0);
        cmp("ovr.sticky",            W'(intf.overrun), 8'd1);
        tick(0, 1, 0, 0, 0);
      end
    end

    // Reset mid-frame: start + 4 data bits, then asynchronous reset.
    cur_word = 8'h77;
    tick(1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) tick(1, 1'(i & 1), 0, 0, 1);
    cmp("mid.busy_before", W'(intf.busy), 8'd1);
    do_reset();
    send_frame(8'h5A, 1, 0, 1, 1, 0);
    cmp("mid.valid", W'(intf.valid), 8'd1);
    cmp("mid.data",  intf.data, 8'h5A);
    tick(0, 1, 1, 0, 0);

    // Randomized frames, back-to-back or gapped, random consumer.
    for (int f = 0; f < 60; f++) begin
      send_frame(W'($urandom), $urandom_range(0, 9) != 0, $urandom_range(0, 2), 0, 0, 1);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++)
        tick(1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)), 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_rx.md
# serial_rx

Serial frame receiver. It accepts a one-bit serial line sampled under an enable strobe and reassembles frames into parallel words. Each frame is a start bit, WIDTH data bits LSB-first, then a stop bit. Completed words are presented on a valid/ready output port. It is the receiving end of the team's enable-gated serial link: the transmitter drives `d` and strobes `en` once per bit.

## Interface
- WIDTH, 8, data bits per frame (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (asserted at 0)
- en  in  1  bit strobe; `d` sampled only on rising `clk` with `en`=1
- d  in  1  serial line; idles high
- data  out  WIDTH  received word; stable while `valid`=1
- valid  out  1  `data` holds an unconsumed word
- ready  in  1  consumer accepts `data` on the edge where `valid`&`ready`
- busy  out  1  frame in progress (state ≠ IDLE)
- frame_err  out  1  one-cycle pulse: stop bit sampled as 0
- overrun  out  1  sticky: a good frame was dropped because `valid` was still set

## Operation
- Reset (rst=0, asynchronous):
  - state=IDLE, bit count=0, shift reg=0.
  - data=0, valid=0, busy=0, frame_err=0, overrun=0.
  - Reset mid-frame aborts the frame; nothing is delivered.
- States: IDLE, DATA, STOP. Every transition happens only on an edge with `en`=1. With `en`=0 the state, count and shift register hold and `d` is ignored.
- IDLE:
  - `d`=0 (start bit) → DATA, count=0.
  - `d`=1 → stay in IDLE.
- DATA:
  - On each strobe, shift `d` in at the MSB and shift right, so bit 0 is received first. Increment count.
  - The strobe with count=WIDTH-1 → STOP.
- STOP, on strobe:
  - `d`=1, `valid`=0, or `valid`&`ready` on this edge → load `data` from the shift register, valid=1.
  - `d`=1, `valid`=1, `ready`=0 → keep the old `data`, drop the new word, overrun=1.
  - `d`=0 → frame_err=1 for one cycle; word discarded; `data` and `valid` unchanged.
  - Always → IDLE.
- Output handshake:
  - `valid`&`ready` with no load on the same edge → valid=0.
  - `ready` while `valid`=0 has no effect.
- `overrun` clears only on reset.
- `frame_err` is 0 on every cycle except the one following a bad stop bit.

## Timing
- Frame length is WIDTH+2 strobes. The minimum is WIDTH+2 consecutive clock cycles, with `en` held at 1.
- `valid` rises at the edge that samples the stop bit; the word is visible in the following cycle. Latency from the stop strobe is 1 edge.
- `busy`:
  - Goes to 1 at the edge that samples the start bit.
  - Goes to 0 at the edge that samples the stop bit.
- Back-to-back frames: a start bit may be sampled on the strobe immediately after the stop strobe (IDLE lasts one strobe).
- A consumer holding `ready`=1 empties the output one edge after `valid` rises. Consecutive frames then never overrun.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `serial_pkg`:
  - State enum `rx_state_t`: IDLE=2'd0, DATA=2'd1, STOP=2'd2.
  - `IDLE_LEVEL` = 1'b1.
  - Shared with the future transmitter.
- Sub-module `sipo_shift`:
  - WIDTH-bit right-shifting register with serial in and parallel out.
  - Asynchronous active-low reset on `clk`/`rst`.
  - Shift enable = `en` & (state==DATA).
- Counter width: $clog2(WIDTH), minimum 1 bit.

## Test plan
- **Basic frame:** reset, then WIDTH=8 with `en`=1 every cycle. Send start 0, bits of 8'hA5 LSB-first, stop 1, with `ready`=1.
  - `valid`=1 for exactly one cycle with data=8'hA5.
  - frame_err=0, overrun=0.
- **Gapped strobes:** send 8'h3C with `en` pulsed every third cycle and `d` toggling randomly between strobes.
  - data=8'h3C.
  - `busy` high from start strobe to stop strobe.
- **Framing error:** send 8'hFF with stop bit 0.
  - frame_err pulses once.
  - `valid` stays 0; `data` unchanged.
  - A following good frame 8'h01 is delivered.
- **Overrun:** `ready`=0, then send 8'h11 followed by 8'h22.
  - data stays 8'h11, valid=1, overrun=1.
  - Then `ready`=1 → valid=0 next cycle; overrun stays 1.
- **Simultaneous load and consume:** `valid`=1 with data=8'h11; assert `ready` on the exact stop-strobe edge of 8'h22.
  - data=8'h22, valid=1, overrun=0.
- **Reset mid-frame:** assert rst=0 after 4 data bits.
  - All outputs 0 immediately (asynchronously).
  - After release, a fresh 8'h5A frame is received correctly.
